mux_feed_arbiter: RTL and testbench

//  Upstream stage of the 4-bit 2:1 output mux. Buffers two independent nibble

---
 rtl/mux_feed_pkg.sv | 19 +
 rtl/mux_feed_arbiter_fifo.sv | 71 +++++++
 rtl/mux_feed_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_feed_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_feed_pkg.sv
// Shared types and defaults for the mux feed arbiter: nibble width, FIFO depth
// and the arbiter FSM state encoding.
package mux_feed_pkg;

    localparam int DATA_W_DEFAULT = 4;
    localparam int DEPTH_DEFAULT  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    // Map a channel index onto the state that serves it.
    function automatic state_t serve_state(input logic ch);
        return ch ? SERVE1 : SERVE0;
    endfunction

endpackage

// File: rtl/mux_feed_arbiter_fifo.sv
// Per-channel nibble FIFO. The head entry is visible on rdata at all times,
// including when the FIFO is empty, so the downstream mux input never floats.
module feed_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mux_feed_arbiter.sv
// Round-robin feeder for the 4-bit 2:1 output mux: two buffered nibble streams,
// a registered select and out_valid, popped on an out_valid/out_ready handshake.
module mux_feed_arbiter
    import mux_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              sel,
    output logic [DATA_W-1:0] din_0,
    output logic [DATA_W-1:0] din_1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t state_reg;
    logic   sel_reg;
    logic   out_valid_reg;
    logic   last_served_reg;

    logic [1:0]        ch_valid;
    logic [1:0]        ch_push;
    logic [1:0]        ch_pop;
    logic [1:0]        ch_full;
    logic [1:0]        ch_empty;
    logic [1:0]        ch_post_ne;
    logic [DATA_W-1:0] ch_wdata [2];
    logic [DATA_W-1:0] ch_rdata [2];
    logic [CNT_W-1:0]  ch_count [2];

    assign ch_valid    = {in1_valid, in0_valid};
    assign ch_wdata[0] = in0_data;
    assign ch_wdata[1] = in1_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            // Ready is a function of occupancy only: a full FIFO never passes through.
            assign ch_push[gi] = ch_valid[gi] && !ch_full[gi];
            assign ch_pop[gi]  = out_valid_reg && out_ready && (sel_reg == 1'(gi));
            // Occupancy after this edge, counting same-edge pushes and pops.
            assign ch_post_ne[gi] = ch_push[gi]
                                 || (ch_count[gi] > CNT_W'(1))
                                 || (!ch_empty[gi] && !ch_pop[gi]);

            feed_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (ch_push[gi]),
                .pop   (ch_pop[gi]),
                .wdata (ch_wdata[gi]),
                .rdata (ch_rdata[gi]),
                .count (ch_count[gi]),
                .full  (ch_full[gi]),
                .empty (ch_empty[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            sel_reg         <= 1'b0;
            out_valid_reg   <= 1'b0;
            last_served_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!ch_empty[0] && !ch_empty[1]) begin
                        state_reg     <= serve_state(~last_served_reg);
                        sel_reg       <= ~last_served_reg;
                        out_valid_reg <= 1'b1;
                    end else if (!ch_empty[0]) begin
                        state_reg     <= SERVE0;
                        sel_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else if (!ch_empty[1]) begin
                        state_reg     <= SERVE1;
                        sel_reg       <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end
                end
                SERVE0, SERVE1: begin
                    // Without out_ready everything holds, keeping sel and din stable.
                    if (out_ready) begin
                        last_served_reg <= sel_reg;
                        if (ch_post_ne[~sel_reg]) begin
                            state_reg <= serve_state(~sel_reg);
                            sel_reg   <= ~sel_reg;
                        end else if (!ch_post_ne[sel_reg]) begin
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in0_ready = !ch_full[0];
    assign in1_ready = !ch_full[1];
    assign out_valid = out_valid_reg;
    assign sel       = sel_reg;
    assign din_0     = ch_rdata[0];
    assign din_1     = ch_rdata[1];

endmodule

// File: tb/tb_mux_feed_arbiter.sv
// Self-checking bench for mux_feed_arbiter: scenario tasks with a queue of
// expected (sel, nibble) transfers popped as the arbiter presents data.
module tb_mux_feed_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in0_valid = 1'b0;
    logic [3:0] in0_data = 4'h0;
    logic       in0_ready;
    logic       in1_valid = 1'b0;
    logic [3:0] in1_data = 4'h0;
    logic       in1_ready;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic       sel;
    logic [3:0] din_0;
    logic [3:0] din_1;

    typedef struct packed {
        logic       sel;
        logic [3:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    mux_feed_arbiter #(.DATA_W(4), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sel       (sel),
        .din_0     (din_0),
        .din_1     (din_1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] presented();
        return sel ? din_1 : din_0;
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        step(2);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in0_valid = 1'b1;
            in1_valid = 1'b1;
            out_ready = (i == 0);
            in0_data  = 4'($urandom_range(1, 15));
            in1_data  = 4'($urandom_range(1, 15));
            step(1);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (sel !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", sel); end
        n_cmp++;
        if (din_0 !== 4'h0) begin n_err++; $display("FAIL reset_din_0: got %h want 0", din_0); end
        n_cmp++;
        if (din_1 !== 4'h0) begin n_err++; $display("FAIL reset_din_1: got %h want 0", din_1); end
        n_cmp++;
        if (in0_ready !== 1'b1) begin n_err++; $display("FAIL reset_in0_ready: got %b want 1", in0_ready); end
        n_cmp++;
        if (in1_ready !== 1'b1) begin n_err++; $display("FAIL reset_in1_ready: got %b want 1", in1_ready); end
        $display("test_reset: outputs checked after 2 reset clocks");
    endtask

    task automatic test_single();
        xfer_t e;
        do_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 4'hA;
        exp_q.push_back('{sel: 1'b0, data: 4'hA});
        step(1);
        in0_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_latency: out_valid got %b want 0 one edge after push", out_valid); end
        step(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {sel, presented()} !== e)
            begin n_err++; $display("FAIL single_xfer: got v=%b sel=%b d=%h want v=1 sel=%b d=%h", out_valid, sel, presented(), e.sel, e.data); end
        $display("single: sel=%b data=%h", sel, presented());
        step(1);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        xfer_t e;
        do_reset();
        in0_valid = 1'b1; in0_data = 4'h1;
        in1_valid = 1'b1; in1_data = 4'h5;
        step(1);
        in0_data = 4'h2;
        in1_data = 4'h6;
        step(1);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        exp_q.push_back('{sel: 1'b0, data: 4'h1});
        exp_q.push_back('{sel: 1'b1, data: 4'h5});
        exp_q.push_back('{sel: 1'b0, data: 4'h2});
        exp_q.push_back('{sel: 1'b1, data: 4'h6});
        out_ready = 1'b1;
        // One transfer per cycle with no bubbles.
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {sel, presented()} !== e)
                begin n_err++; $display("FAIL rr_xfer: got v=%b sel=%b d=%h want v=1 sel=%b d=%h", out_valid, sel, presented(), e.sel, e.data); end
            $display("round_robin: sel=%b data=%h", sel, presented());
            step(1);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained: out_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        xfer_t e;
        do_reset();
        in1_valid = 1'b1;
        in1_data  = 4'h7;
        exp_q.push_back('{sel: 1'b1, data: 4'h7});
        step(1);
        in1_valid = 1'b0;
        step(1);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || sel !== 1'b1 || din_1 !== 4'h7)
                begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b sel=%b din_1=%h want v=1 sel=1 din_1=7", c, out_valid, sel, din_1); end
            if (c == 0) begin
                in1_valid = 1'b1;
                in1_data  = 4'h8;
                exp_q.push_back('{sel: 1'b1, data: 4'h8});
            end else if (c == 1) begin
                n_cmp++;
                if (in1_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: in1_ready got %b want 0", in1_ready); end
                in1_data = 4'h9;
            end else begin
                in1_valid = 1'b0;
            end
            step(1);
        end
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {sel, presented()} !== e)
                begin n_err++; $display("FAIL bp_xfer: got v=%b sel=%b d=%h want v=1 sel=%b d=%h", out_valid, sel, presented(), e.sel, e.data); end
            $display("backpressure: sel=%b data=%h", sel, presented());
            step(1);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_rejected_push: out_valid got %b want 0 (nibble 9 must not be stored)", out_valid); end
        n_cmp++;
        if (sel !== 1'b1) begin n_err++; $display("FAIL idle_sel_hold: sel got %b want 1", sel); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_simultaneous();
        xfer_t e;
        do_reset();
        in0_valid = 1'b1;
        in0_data  = 4'h3;
        exp_q.push_back('{sel: 1'b0, data: 4'h3});
        step(1);
        in0_data = 4'h4;
        exp_q.push_back('{sel: 1'b0, data: 4'h4});
        step(1);
        // Offer 9 while full: refused this edge, taken on the next alongside a pop.
        in0_data = 4'h9;
        n_cmp++;
        if (in0_ready !== 1'b0) begin n_err++; $display("FAIL full0_ready: in0_ready got %b want 0", in0_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || {sel, presented()} !== e)
                begin n_err++; $display("FAIL full_xfer[%0d]: got v=%b sel=%b d=%h want v=1 sel=%b d=%h", c, out_valid, sel, presented(), e.sel, e.data); end
            $display("full_simultaneous: sel=%b data=%h", sel, presented());
            if (c == 0) exp_q.push_back('{sel: 1'b0, data: 4'h9});
            step(1);
            if (c == 1) in0_valid = 1'b0;
            if (c < 2) begin
                n_cmp++;
                if (in0_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready[%0d]: in0_ready got %b want 1", c, in0_ready); end
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: out_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_midop_reset();
        xfer_t e;
        do_reset();
        in0_valid = 1'b1; in0_data = 4'h1;
        in1_valid = 1'b1; in1_data = 4'h5;
        step(1);
        in0_data = 4'h2;
        in1_data = 4'h6;
        step(1);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || sel !== 1'b1)
            begin n_err++; $display("FAIL midop_pre: got v=%b sel=%b want v=1 sel=1", out_valid, sel); end
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        n_cmp++;
        if ({out_valid, sel, din_0, din_1, in0_ready, in1_ready} !== {1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1})
            begin n_err++; $display("FAIL midop_cleared: got v=%b sel=%b d0=%h d1=%h r0=%b r1=%b want 0 0 0 0 1 1",
                                    out_valid, sel, din_0, din_1, in0_ready, in1_ready); end
        in1_valid = 1'b1;
        in1_data  = 4'hC;
        exp_q.push_back('{sel: 1'b1, data: 4'hC});
        step(1);
        in1_valid = 1'b0;
        out_ready = 1'b1;
        step(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || {sel, presented()} !== e)
            begin n_err++; $display("FAIL midop_xfer: got v=%b sel=%b d=%h want v=1 sel=%b d=%h", out_valid, sel, presented(), e.sel, e.data); end
        $display("midop_reset: sel=%b data=%h", sel, presented());
        step(1);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midop_idle: out_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_full_simultaneous();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
